// File: rtl/dpi_stream_sequencer.sv
// Maps flow keys to stream IDs via a 64-entry flow table and feeds the matcher slices.
// The bus timing spaces a state restore before the first byte and a state save after the last byte.
module dpi_stream_sequencer #(
  parameter int FLOW_W    = 32,
  parameter int SID_W     = 6,
  parameter int LOAD_GAP  = 2,
  parameter int EOP_DELAY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [FLOW_W-1:0] in_flow_key,
  input  logic              cfg_flush,
  output logic              load_state,
  output logic              new_stream_id,
  output logic [SID_W-1:0]  stream_id,
  output logic [7:0]        char_in,
  output logic              char_in_vld,
  output logic              eop,
  output logic              busy,
  output logic [15:0]       pkt_count,
  output logic [15:0]       drop_count
);
  localparam int DEPTH = 1 << SID_W;
  localparam logic [7:0] GAP_LAST   = 8'(LOAD_GAP - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(EOP_DELAY - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, LOAD, GAP, STREAM, DRAIN, EOP} state_t;
  state_t state;

  logic [FLOW_W-1:0] key_q;
  logic [FLOW_W-1:0] tbl_key [DEPTH];
  logic [DEPTH-1:0]  tbl_vld;
  logic [SID_W-1:0]  victim;
  logic [7:0]        cnt;

  logic              hit;
  logic              free_found;
  logic [SID_W-1:0]  hit_idx;
  logic [SID_W-1:0]  free_idx;
  logic [SID_W-1:0]  alloc_idx;

  // Descending scan so the lowest matching / lowest free index wins.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (tbl_vld[i] && (tbl_key[i] == key_q)) begin
        hit     = 1'b1;
        hit_idx = SID_W'(i);
      end
      if (!tbl_vld[i]) begin
        free_found = 1'b1;
        free_idx   = SID_W'(i);
      end
    end
    alloc_idx = free_found ? free_idx : victim;
  end

  assign in_ready = !rst && ((state == STREAM) ||
                             (state == IDLE && in_valid && !in_sop && !cfg_flush));
  assign busy     = (state != IDLE);

  // Key storage needs no reset: entries are qualified by tbl_vld.
  always_ff @(posedge clk) begin
    if (state == LOOKUP && !hit) tbl_key[alloc_idx] <= key_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tbl_vld       <= '0;
      victim        <= '0;
      key_q         <= '0;
      cnt           <= '0;
      load_state    <= 1'b0;
      new_stream_id <= 1'b0;
      stream_id     <= '0;
      char_in       <= '0;
      char_in_vld   <= 1'b0;
      eop           <= 1'b0;
      pkt_count     <= '0;
      drop_count    <= '0;
    end else begin
      load_state  <= 1'b0;
      eop         <= 1'b0;
      char_in_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_flush) begin
            tbl_vld <= '0;
            victim  <= '0;
          end else if (in_valid && in_sop) begin
            key_q <= in_flow_key;
            state <= LOOKUP;
          end else if (in_valid) begin
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
          end
        end
        LOOKUP: begin
          if (hit) begin
            stream_id     <= hit_idx;
            new_stream_id <= 1'b0;
          end else begin
            stream_id          <= alloc_idx;
            new_stream_id      <= 1'b1;
            tbl_vld[alloc_idx] <= 1'b1;
            if (!free_found) victim <= victim + 1'b1;
          end
          load_state <= 1'b1;
          state      <= LOAD;
        end
        LOAD: begin
          cnt   <= '0;
          state <= GAP;
        end
        GAP: begin
          if (cnt == GAP_LAST) state <= STREAM;
          else                 cnt   <= cnt + 8'd1;
        end
        STREAM: begin
          if (in_valid) begin
            char_in     <= in_data;
            char_in_vld <= 1'b1;
            if (in_eop) begin
              cnt   <= '0;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            eop   <= 1'b1;
            if (pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
            state <= EOP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        EOP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Directed bench for dpi_stream_sequencer: timing, allocation, eviction, flush, drops and reset.
module tb_dpi_stream_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sop, in_eop, cfg_flush;
  logic [7:0]  in_data;
  logic [31:0] in_flow_key;
  logic        load_state, new_stream_id, char_in_vld, eop, busy;
  logic [5:0]  stream_id;
  logic [7:0]  char_in;
  logic [15:0] pkt_count, drop_count;

  dpi_stream_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_flow_key(in_flow_key), .cfg_flush(cfg_flush),
    .load_state(load_state), .new_stream_id(new_stream_id), .stream_id(stream_id),
    .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop), .busy(busy),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int t0 = 0;
  int last_acc = 0;
  int ls_cnt, ls_cyc, vld_cnt, first_vld, last_vld, eop_cnt, eop_cyc;
  logic [5:0] ls_sid, eop_sid;
  logic       ls_new;

  always @(negedge clk) begin
    if (!rst) begin
      if (load_state) begin
        ls_cnt++;
        ls_cyc = cyc - t0;
        ls_sid = stream_id;
        ls_new = new_stream_id;
      end
      if (char_in_vld) begin
        if (vld_cnt == 0) first_vld = cyc - t0;
        last_vld = cyc - t0;
        vld_cnt++;
      end
      if (eop) begin
        eop_cnt++;
        eop_cyc = cyc - t0;
        eop_sid = stream_id;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rec();
    ls_cnt = 0; ls_cyc = -1; vld_cnt = 0; first_vld = -1; last_vld = -1;
    eop_cnt = 0; eop_cyc = -1; ls_sid = '0; ls_new = 1'b0; eop_sid = '0;
  endtask

  // Sends one packet of n bytes starting at d0 and waits for its eop.
  task automatic send(input logic [31:0] key, input int n, input logic [7:0] d0, input bit flush_mid);
    int  i = 0;
    int  guard = 0;
    bit  acc;
    clear_rec();
    @(posedge clk); #1;
    in_valid = 1'b1; in_sop = 1'b1; in_flow_key = key; in_data = d0; in_eop = (n == 1);
    t0 = cyc;
    while (i < n && guard < 200) begin
      @(negedge clk);
      acc = in_ready;
      if (acc && i == n - 1) last_acc = cyc - t0;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        i++;
        if (flush_mid && i == 1) cfg_flush = 1'b1;
        if (flush_mid && i == 3) cfg_flush = 1'b0;
        if (i < n) begin
          in_sop = 1'b0; in_data = d0 + 8'(i); in_eop = (i == n - 1);
        end else begin
          in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        end
      end
    end
    chk("bytes_sent", i, n);
    guard = 0;
    while (eop_cnt == 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("eop_seen", eop_cnt, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; cfg_flush = 1'b0;
    in_data = 8'h00; in_flow_key = 32'h0;
    clear_rec();
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {in_ready, load_state, new_stream_id, stream_id, char_in, char_in_vld, eop, busy}, 0);
    chk("rst_cnt", {pkt_count, drop_count}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // First packet: exact latencies.
    send(32'hA5A5_0001, 3, 8'h41, 1'b0);
    chk("p1_ls_cyc", ls_cyc, 2);
    chk("p1_sid", ls_sid, 0);
    chk("p1_new", ls_new, 1);
    chk("p1_first_vld", first_vld, 6);
    chk("p1_last_vld", last_vld, 8);
    chk("p1_vld_cnt", vld_cnt, 3);
    chk("p1_eop_cyc", eop_cyc, 12);
    chk("p1_eop_sid", eop_sid, 0);
    chk("p1_pkt_count", pkt_count, 1);

    send(32'hA5A5_0001, 2, 8'h10, 1'b0);
    chk("hit_sid", ls_sid, 0);
    chk("hit_new", ls_new, 0);
    send(32'hA5A5_0002, 2, 8'h20, 1'b0);
    chk("k2_sid", ls_sid, 1);
    chk("k2_new", ls_new, 1);

    // Single-byte packet.
    send(32'hA5A5_0003, 1, 8'h7E, 1'b0);
    chk("one_vld_cnt", vld_cnt, 1);
    chk("one_eop_delta", eop_cyc - last_acc, 5);
    chk("one_sid", ls_sid, 2);

    // Two non-sop bytes in IDLE are dropped.
    clear_rec();
    @(posedge clk); #1 in_valid = 1'b1; in_sop = 1'b0; in_data = 8'hEE;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("drop_rdy", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("drop_count", drop_count, 2);
    chk("drop_no_load", ls_cnt, 0);
    chk("drop_busy", busy, 0);

    send(32'hA5A5_0004, 2, 8'h30, 1'b0);
    chk("k4_sid", ls_sid, 3);
    send(32'hA5A5_0005, 2, 8'h38, 1'b0);
    chk("k5_sid", ls_sid, 4);

    // Flush in IDLE empties the table.
    @(posedge clk); #1 cfg_flush = 1'b1;
    @(posedge clk); #1 cfg_flush = 1'b0;
    send(32'hA5A5_0002, 2, 8'h50, 1'b0);
    chk("flush_sid", ls_sid, 0);
    chk("flush_new", ls_new, 1);

    // Flush while streaming is ignored.
    send(32'hA5A5_0001, 4, 8'h60, 1'b1);
    chk("fmid_sid", ls_sid, 1);
    chk("fmid_new", ls_new, 1);
    send(32'hA5A5_0002, 2, 8'h68, 1'b0);
    chk("fmid_hit_sid", ls_sid, 0);
    chk("fmid_hit_new", ls_new, 0);
    chk("pkt_count9", pkt_count, 9);

    // Fill the table then evict round-robin.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 64; k++) begin
      send(32'h0000_1000 + k, 1, 8'(k), 1'b0);
      chk($sformatf("fill_sid_%0d", k), ls_sid, k);
      chk($sformatf("fill_new_%0d", k), ls_new, 1);
    end
    send(32'h0000_1040, 1, 8'h01, 1'b0);
    chk("evict65_sid", ls_sid, 0);
    chk("evict65_new", ls_new, 1);
    send(32'h0000_1041, 1, 8'h02, 1'b0);
    chk("evict66_sid", ls_sid, 1);
    send(32'h0000_1000, 1, 8'h03, 1'b0);
    chk("evicted_sid", ls_sid, 2);
    chk("evicted_new", ls_new, 1);
    chk("pkt_count67", pkt_count, 67);

    // Reset in the middle of a packet.
    clear_rec();
    @(posedge clk); #1;
    in_valid = 1'b1; in_sop = 1'b1; in_flow_key = 32'h2222_0000; in_data = 8'h91; in_eop = 1'b0;
    t0 = cyc;
    begin
      int g = 0;
      @(negedge clk);
      while (!in_ready && g < 20) begin
        @(negedge clk);
        g++;
      end
      chk("mid_ready", in_ready, 1);
    end
    @(posedge clk); #1 in_sop = 1'b0; in_data = 8'h92;
    @(posedge clk); #1 in_data = 8'h93;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", {in_ready, load_state, new_stream_id, stream_id, char_in, char_in_vld, eop, busy}, 0);
    chk("mid_rst_cnt", {pkt_count, drop_count}, 0);
    in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    eop_cnt = 0;
    repeat (10) @(negedge clk);
    chk("mid_no_eop", eop_cnt, 0);
    send(32'h0000_1001, 2, 8'hA0, 1'b0);
    chk("post_rst_sid", ls_sid, 0);
    chk("post_rst_new", ls_new, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dpi_stream_sequencer.md
Name: dpi_stream_sequencer

Overview:
Upstream feeder for the per-regex matcher slices. Accepts a byte-serial packet stream tagged with a flow key and maps the key to a 6-bit stream ID through a 64-entry flow table, allocating on miss. Drives the slices' shared load_state/stream_id/new_stream_id/char_in/char_in_vld/eop bus with the spacing the slices' registered DFA pipeline needs for state restore and state save.

Parameters:
FLOW_W, 32, flow key width
SID_W, 6, stream ID width; table depth is 2**SID_W (64)
LOAD_GAP, 2, idle cycles between load_state and the first accepted byte (min 1)
EOP_DELAY, 4, cycles between the last char_in_vld and the eop pulse (min 1)

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input byte valid
in_ready  out  1  byte consumed when in_valid & in_ready
in_data  in  8  packet byte
in_sop  in  1  first byte of packet; qualifies in_flow_key
in_eop  in  1  last byte of packet (may coincide with in_sop)
in_flow_key  in  FLOW_W  flow key, valid with in_valid & in_sop
cfg_flush  in  1  invalidate whole flow table (acted on in IDLE only)
load_state  out  1  one-cycle pulse: slices restore state for stream_id
new_stream_id  out  1  qualifies load_state: stream is newly allocated
stream_id  out  SID_W  current stream ID, stable from load_state through eop inclusive
char_in  out  8  registered byte to slices
char_in_vld  out  1  char_in valid
eop  out  1  one-cycle pulse: slices commit count and save state
busy  out  1  high in any state other than IDLE
pkt_count  out  16  packets completed (counted at eop), saturating
drop_count  out  16  bytes discarded in IDLE without in_sop, saturating

Behaviour:
- Reset (async, rst=1): FSM to IDLE; all table valid bits 0; victim pointer 0; all outputs 0 (in_ready, load_state, new_stream_id, stream_id, char_in, char_in_vld, eop, busy, both counters). Reset mid-packet abandons the packet; no eop issued.
- FSM: IDLE, LOOKUP, LOAD, GAP, STREAM, DRAIN, EOP.
- IDLE: in_valid & in_sop -> capture in_flow_key, do not consume byte (in_ready=0), go LOOKUP. in_valid & ~in_sop -> in_ready=1, byte discarded, drop_count+1. cfg_flush=1 (priority over sop) -> clear all valid bits and victim pointer in one cycle, stay IDLE.
- LOOKUP (1 cycle): parallel compare against all valid entries. Hit -> stream_id=hit index, new_stream_id=0. Miss with free entry -> lowest-index invalid entry, write key, set valid, new_stream_id=1. Miss with table full -> overwrite entry at victim pointer, new_stream_id=1, victim pointer +1 (wraps 63->0). Go LOAD.
- LOAD (1 cycle): load_state=1. Go GAP.
- GAP: LOAD_GAP cycles, then STREAM.
- STREAM: in_ready=1. Each accepted byte -> char_in=in_data, char_in_vld=1 on the next cycle. in_sop seen on a non-first byte is ignored (treated as data). Byte with in_eop accepted -> in_ready drops the next cycle, go DRAIN.
- DRAIN: EOP_DELAY cycles, then EOP.
- EOP (1 cycle): eop=1, pkt_count+1 (holds at 0xFFFF), go IDLE. A new sop may be sampled the following cycle.
- Latency from sop presented at cycle 0 in IDLE: load_state at 2; first in_ready at 3+LOAD_GAP; first char_in_vld at 4+LOAD_GAP. Last byte accepted at cycle E -> last char_in_vld at E+1, eop at E+EOP_DELAY+1.
- No downstream backpressure; slices always accept.
- cfg_flush outside IDLE is ignored; the requester holds it until busy=0.

Test Plan:
- After reset, 3-byte packet key 0xA5A5_0001 (LOAD_GAP=2, EOP_DELAY=4) -> load_state at cycle 2 with stream_id 0, new_stream_id 1; char_in_vld at cycles 6-8; eop at cycle 12; pkt_count=1.
- Same key again -> stream_id 0, new_stream_id 0. A second key -> stream_id 1, new_stream_id 1.
- 65 distinct keys -> 65th gets stream_id 0 (victim), new_stream_id 1; 66th gets stream_id 1; first key then misses.
- 1-byte packet (in_sop & in_eop) -> exactly one char_in_vld, eop EOP_DELAY+1 cycles after that byte is accepted. Two non-sop bytes in IDLE -> drop_count=2, no load_state.
- cfg_flush in IDLE after 5 allocations -> next known key returns stream_id 0 with new_stream_id 1. cfg_flush during STREAM -> no effect.
- rst asserted mid-STREAM -> all outputs 0 immediately, no eop; next packet is allocated stream_id 0 as new.
